// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, canonical NOP encoding and
// the IF/ID responder state encoding.
package pipe_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear; it sticks at all-ones.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign count = cnt_q;

endmodule

// File: rtl/if_id_hold_reg.sv
// IF/ID pipeline register with stall/flush handling, PC write gating,
// saturating perf counters and a consecutive-stall watchdog.
module if_id_hold_reg #(
   parameter int unsigned XLEN      = pipe_pkg::XLEN,
   parameter int unsigned MAX_STALL = 16,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_in,
   input  logic             flush_in,
   input  logic [XLEN-1:0]  if_pc_in,
   input  logic [XLEN-1:0]  if_instr_in,
   output logic             pc_write_out,
   output logic             id_ex_bubble_out,
   output logic [XLEN-1:0]  if_id_pc_out,
   output logic [XLEN-1:0]  if_id_instr_out,
   output logic             if_id_valid_out,
   output logic [1:0]       state_out,
   output logic [CNT_W-1:0] stall_cycles_out,
   output logic [CNT_W-1:0] flush_count_out,
   output logic             stall_timeout_out
);

   import pipe_pkg::*;

   localparam int unsigned CS_W = $clog2(MAX_STALL + 1);
   localparam logic [CS_W-1:0] CS_MAX = CS_W'(MAX_STALL);
   localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic            valid_q, valid_d;
   state_t          state_q, state_d;
   logic [CS_W-1:0] consec_q, consec_d;
   logic            timeout_q, timeout_d;

   logic do_flush;
   logic do_stall;

   assign do_flush = !rst && flush_in;
   assign do_stall = !rst && !flush_in && stall_in;

   assign pc_write_out     = !rst && (flush_in || !stall_in);
   assign id_ex_bubble_out = rst || flush_in || stall_in;

   always_comb begin
      pc_d      = pc_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      state_d   = state_q;
      consec_d  = consec_q;
      timeout_d = timeout_q;
      if (rst) begin
         pc_d      = '0;
         instr_d   = NOP;
         valid_d   = 1'b0;
         state_d   = ST_RUN;
         consec_d  = '0;
         timeout_d = 1'b0;
      end else if (flush_in) begin
         pc_d     = '0;
         instr_d  = NOP;
         valid_d  = 1'b0;
         state_d  = ST_FLUSH;
         consec_d = '0;
      end else if (stall_in) begin
         state_d = ST_HOLD;
         if (consec_q != CS_MAX) begin
            consec_d = consec_q + 1'b1;
         end
         // Sticky: set on the edge the run reaches the limit, held until reset.
         if (consec_d == CS_MAX) begin
            timeout_d = 1'b1;
         end
      end else begin
         pc_d     = if_pc_in;
         instr_d  = if_instr_in;
         valid_d  = 1'b1;
         state_d  = ST_RUN;
         consec_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      state_q   <= state_d;
      consec_q  <= consec_d;
      timeout_q <= timeout_d;
   end

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .inc   (do_stall),
      .clr   (rst),
      .count (stall_cycles_out)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .inc   (do_flush),
      .clr   (rst),
      .count (flush_count_out)
   );

   assign if_id_pc_out      = pc_q;
   assign if_id_instr_out   = instr_q;
   assign if_id_valid_out   = valid_q;
   assign state_out         = state_q;
   assign stall_timeout_out = timeout_q;

endmodule

// File: tb/tb_if_id_hold_reg.sv
// Directed plus random bench for if_id_hold_reg against a cycle-level
// behavioural model of the stall/flush rules.
module tb_if_id_hold_reg;

   localparam int XLEN      = 32;
   localparam int MAX_STALL = 4;
   localparam int CNT_W     = 4;
   localparam int CMAX      = (1 << CNT_W) - 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             stall_in = 1'b0;
   logic             flush_in = 1'b0;
   logic [XLEN-1:0]  if_pc_in = '0;
   logic [XLEN-1:0]  if_instr_in = '0;
   logic             pc_write_out;
   logic             id_ex_bubble_out;
   logic [XLEN-1:0]  if_id_pc_out;
   logic [XLEN-1:0]  if_id_instr_out;
   logic             if_id_valid_out;
   logic [1:0]       state_out;
   logic [CNT_W-1:0] stall_cycles_out;
   logic [CNT_W-1:0] flush_count_out;
   logic             stall_timeout_out;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [31:0] m_pc = '0;
   logic [31:0] m_instr = '0;
   int m_valid = 0, m_state = 0, m_sc = 0, m_fc = 0, m_run = 0, m_to = 0;

   if_id_hold_reg #(
      .XLEN      (XLEN),
      .MAX_STALL (MAX_STALL),
      .CNT_W     (CNT_W)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .stall_in          (stall_in),
      .flush_in          (flush_in),
      .if_pc_in          (if_pc_in),
      .if_instr_in       (if_instr_in),
      .pc_write_out      (pc_write_out),
      .id_ex_bubble_out  (id_ex_bubble_out),
      .if_id_pc_out      (if_id_pc_out),
      .if_id_instr_out   (if_id_instr_out),
      .if_id_valid_out   (if_id_valid_out),
      .state_out         (state_out),
      .stall_cycles_out  (stall_cycles_out),
      .flush_count_out   (flush_count_out),
      .stall_timeout_out (stall_timeout_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic f,
                       input logic [31:0] pc, input logic [31:0] ins);
      rst = r; stall_in = s; flush_in = f; if_pc_in = pc; if_instr_in = ins;
      #1;
      chk("pc_write", 64'(pc_write_out), 64'(!r && (f || !s)));
      chk("bubble", 64'(id_ex_bubble_out), 64'(r || f || s));
      @(posedge clk);
      if (r) begin
         m_pc = '0; m_instr = NOP; m_valid = 0; m_state = 0;
         m_sc = 0; m_fc = 0; m_run = 0; m_to = 0;
      end else if (f) begin
         m_pc = '0; m_instr = NOP; m_valid = 0; m_state = 2; m_run = 0;
         m_fc = (m_fc < CMAX) ? m_fc + 1 : m_fc;
      end else if (s) begin
         m_state = 1;
         m_sc  = (m_sc < CMAX) ? m_sc + 1 : m_sc;
         m_run = (m_run < MAX_STALL) ? m_run + 1 : m_run;
         if (m_run == MAX_STALL) m_to = 1;
      end else begin
         m_pc = pc; m_instr = ins; m_valid = 1; m_state = 0; m_run = 0;
      end
      #1;
      chk("if_id_pc", 64'(if_id_pc_out), 64'(m_pc));
      chk("if_id_instr", 64'(if_id_instr_out), 64'(m_instr));
      chk("if_id_valid", 64'(if_id_valid_out), 64'(m_valid));
      chk("state", 64'(state_out), 64'(m_state));
      chk("stall_cycles", 64'(stall_cycles_out), 64'(m_sc));
      chk("flush_count", 64'(flush_count_out), 64'(m_fc));
      chk("timeout", 64'(stall_timeout_out), 64'(m_to));
   endtask

   initial begin
      // reset held two cycles with a pending stall
      step(1, 1, 0, 32'h44, 32'h55);
      step(1, 1, 0, 32'h48, 32'h59);
      chk("rst_pc_const", 64'(if_id_pc_out), 64'h0);
      chk("rst_instr_const", 64'(if_id_instr_out), 64'h13);

      // advance then 3-cycle stall with changing inputs
      step(0, 0, 0, 32'h100, 32'h00A0_0093);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h104 + 4 * i, 32'h1111_0000 + i);
      chk("hold_pc_const", 64'(if_id_pc_out), 64'h100);
      chk("hold_cnt_const", 64'(stall_cycles_out), 64'd3);
      step(0, 0, 0, 32'h104, 32'h0020_0113);

      // flush, then stall+flush together
      step(0, 0, 1, 32'h200, 32'hDEAD_BEEF);
      chk("flush_cnt_const", 64'(flush_count_out), 64'd1);
      step(0, 1, 1, 32'h204, 32'h0030_0193);
      chk("sf_stall_const", 64'(stall_cycles_out), 64'd3);
      chk("sf_flush_const", 64'(flush_count_out), 64'd2);

      // watchdog: 3 stalls, advance, 4 stalls
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h300, 32'h1);
      step(0, 0, 0, 32'h304, 32'h2);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h308, 32'h3);
      chk("wd_before_const", 64'(stall_timeout_out), 64'd0);
      step(0, 1, 0, 32'h308, 32'h3);
      chk("wd_set_const", 64'(stall_timeout_out), 64'd1);
      step(0, 0, 0, 32'h30C, 32'h4);
      step(0, 0, 1, 32'h310, 32'h5);
      step(1, 1, 1, 32'h314, 32'h6);

      // saturation: 20 stall cycles on a 4-bit counter
      for (int i = 0; i < 20; i++) step(0, 1, 0, 32'h400 + i, 32'h7);
      chk("sat_const", 64'(stall_cycles_out), 64'd15);

      // random traffic, reset rare
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 99) < 55),
              ($urandom_range(0, 99) < 15), $urandom, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_id_hold_reg.md
# if_id_hold_reg

IF/ID pipeline register and stall/flush responder for the 5-stage core. It consumes the single-bit stall request from the hazard-detection unit and the branch-flush request from EX. It gates the PC write, holds or bubbles the IF/ID latch, and tells ID/EX to latch a NOP. It also keeps saturating stall/flush performance counters and a watchdog that flags a stall held too long.

## Interface
Parameters:
- XLEN, 32, PC/instruction width
- MAX_STALL, 16, consecutive-stall cycles that set the watchdog flag (≥1)
- CNT_W, 16, perf counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall_in  in  1  hazard request (load-use / regwrite RAW), valid same cycle
- flush_in  in  1  taken branch/jump resolved in EX
- if_pc_in  in  XLEN  PC of instruction currently in IF
- if_instr_in  in  XLEN  fetched instruction
- pc_write_out  out  1  PC register write enable (combinational)
- id_ex_bubble_out  out  1  ID/EX must latch NOP controls this edge (combinational)
- if_id_pc_out  out  XLEN  registered PC for ID
- if_id_instr_out  out  XLEN  registered instruction for ID
- if_id_valid_out  out  1  IF/ID holds a real instruction
- state_out  out  2  RUN=0, HOLD=1, FLUSH=2
- stall_cycles_out  out  CNT_W  saturating count of stalled cycles
- flush_count_out  out  CNT_W  saturating count of flushes
- stall_timeout_out  out  1  sticky watchdog flag

## Operation
- Priority per cycle: rst > flush_in > stall_in > advance.
- rst: next edge → pc_out=0, instr_out=NOP (0x00000013), valid=0, state RUN, both counters 0, consecutive-stall count 0, timeout 0. While rst=1: pc_write_out=0, id_ex_bubble_out=1.
- flush_in=1 (stall_in ignored): pc_write_out=1 (PC loads target); id_ex_bubble_out=1; edge → IF/ID ← NOP, pc_out=0, valid=0; state FLUSH; flush_count+1; consecutive-stall count cleared.
- stall_in=1, flush_in=0: pc_write_out=0; id_ex_bubble_out=1; IF/ID holds pc/instr/valid unchanged; state HOLD; stall_cycles+1; consecutive-stall count +1 (saturates at MAX_STALL).
- Neither: pc_write_out=1; id_ex_bubble_out=0; IF/ID ← if_pc_in/if_instr_in, valid=1; state RUN; consecutive-stall count cleared.
- Watchdog: the edge on which the consecutive-stall count reaches MAX_STALL sets stall_timeout_out=1. It stays set until rst.
- Counters saturate at all-ones and never wrap.
- State transitions from any state follow priority only: no state blocks any request.

## Timing
- pc_write_out and id_ex_bubble_out: zero latency from stall_in/flush_in/rst.
- IF/ID outputs, state_out, counters and timeout flag: registered, 1-cycle latency.
- Stall held N cycles: IF/ID constant for N edges; advance resumes on the first cycle with stall_in=0.
- Stall and flush in the same cycle: flush wins; stall_cycles is not incremented.
- Reset mid-stall or mid-flush: reset wins that edge; there is no residual HOLD/FLUSH.
- MAX_STALL=1: a single stall cycle sets the timeout.

## Structure
- Shared package pipe_pkg: XLEN, NOP_INSTR=32'h00000013, state enum (RUN/HOLD/FLUSH).
- One sub-module sat_counter (parameter width; inc, clr; saturating), instantiated for stall_cycles and flush_count.
- Consecutive-stall counter and FSM stay inline.

## Test plan
- Reset: assert rst 2 cycles with stall_in=1 → pc_out=0, instr_out=0x00000013, valid=0, state 0, counters 0, pc_write_out=0, id_ex_bubble_out=1.
- Advance then stall: present pc=0x100, instr=0x00A00093, no stall; then stall_in=1 for 3 cycles with new inputs → IF/ID holds 0x100/0x00A00093, pc_write_out=0 and bubble=1 each of those cycles, stall_cycles=3, state HOLD; stall low → next edge latches the new input.
- Flush: flush_in=1 one cycle with pc=0x200 → pc_write_out=1, bubble=1, next edge valid=0, instr=NOP, state FLUSH, flush_count=1.
- Simultaneous stall+flush → flush behaviour; stall_cycles unchanged, flush_count+1.
- Watchdog with MAX_STALL=4: 3 stalls, 1 advance, 4 stalls → timeout rises on the 4th consecutive stall edge only; stays 1 after stall drops; clears only on rst.
- Saturation with CNT_W=4: 20 stall cycles → stall_cycles=15, no wrap.
